// File: rtl/work_dispatcher.sv
// Round-robin work dispatcher: per-queue pending counters, a kernel PC table and a
// three-state grant FSM that hands one start PC to one idle core at a time.
module work_dispatcher #(
  parameter int NUM_CORES  = 4,
  parameter int NUM_QUEUES = 16,
  parameter int CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_wen,
  input  logic [3:0]             cfg_queue,
  input  logic [15:0]            cfg_pc,
  input  logic [NUM_CORES-1:0]   queue_wen,
  input  logic [4*NUM_CORES-1:0] queue_number,
  input  logic [NUM_CORES-1:0]   request_new_pc,
  output logic [NUM_CORES-1:0]   set_pc,
  output logic [15:0]            new_pc,
  output logic                   busy,
  output logic                   overflow
);
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int IW = $clog2(NUM_CORES + 1);
  localparam int SW = CNT_W + IW + 1;
  localparam logic [SW-1:0] CNT_MAX = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            q_ptr_reg;
  logic [CW-1:0]         c_ptr_reg;
  logic [NUM_CORES-1:0]  mask_reg;
  logic [NUM_CORES-1:0]  set_pc_reg;
  logic [15:0]           new_pc_reg;
  logic                  overflow_reg;
  logic [15:0]           pc_table [NUM_QUEUES];

  logic [NUM_QUEUES-1:0] pending;
  logic [NUM_QUEUES-1:0] ovf_hit;
  logic [NUM_CORES-1:0]  req_avail;
  logic [3:0]            q_sel;
  logic                  q_found;
  logic [4:0]            q_idx;
  logic [CW-1:0]         c_sel;
  logic                  c_found;
  logic [CW:0]           c_idx;
  logic                  decide;

  assign req_avail = request_new_pc & ~mask_reg;

  // Scan downwards so the candidate closest to the pointer is the one left standing.
  always_comb begin
    q_sel   = q_ptr_reg;
    q_found = 1'b0;
    q_idx   = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      q_idx = {1'b0, q_ptr_reg} + 5'(i);
      if (q_idx >= 5'(NUM_QUEUES)) q_idx = q_idx - 5'(NUM_QUEUES);
      if (pending[q_idx[3:0]]) begin
        q_sel   = q_idx[3:0];
        q_found = 1'b1;
      end
    end
  end

  always_comb begin
    c_sel   = c_ptr_reg;
    c_found = 1'b0;
    c_idx   = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      c_idx = {1'b0, c_ptr_reg} + (CW+1)'(i);
      if (c_idx >= (CW+1)'(NUM_CORES)) c_idx = c_idx - (CW+1)'(NUM_CORES);
      if (req_avail[c_idx[CW-1:0]]) begin
        c_sel   = c_idx[CW-1:0];
        c_found = 1'b1;
      end
    end
  end

  assign decide = (state_reg == IDLE) && q_found && c_found;

  // Per-queue counter: all same-cycle pushes plus a possible dispatch, saturating.
  for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
    logic [IW-1:0]    inc;
    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] cnt_reg;

    always_comb begin
      inc = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (queue_wen[c] && (queue_number[4*c +: 4] == 4'(gi))) inc = inc + IW'(1);
      end
      sum = SW'(cnt_reg) + SW'(inc) - SW'(decide && (q_sel == 4'(gi)));
    end

    assign ovf_hit[gi] = (sum > CNT_MAX);
    assign pending[gi] = |cnt_reg;

    always_ff @(posedge clk) begin
      if (rst) cnt_reg <= '0;
      else     cnt_reg <= ovf_hit[gi] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end

  // Kernel table; a same-edge decide reads the value from before this write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_QUEUES; i++) pc_table[i] <= '0;
    end else if (cfg_wen && ({1'b0, cfg_queue} < 5'(NUM_QUEUES))) begin
      pc_table[cfg_queue] <= cfg_pc;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (decide) state_next = GRANT;
      GRANT:    state_next = COOLDOWN;
      COOLDOWN: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      q_ptr_reg    <= '0;
      c_ptr_reg    <= '0;
      mask_reg     <= '0;
      set_pc_reg   <= '0;
      new_pc_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      overflow_reg <= overflow_reg | (|ovf_hit);
      set_pc_reg   <= '0;
      if (decide) begin
        set_pc_reg <= NUM_CORES'(1) << c_sel;
        new_pc_reg <= pc_table[q_sel];
        q_ptr_reg  <= (q_sel == 4'(NUM_QUEUES - 1)) ? 4'd0 : q_sel + 4'd1;
        c_ptr_reg  <= (c_sel == CW'(NUM_CORES - 1)) ? '0 : c_sel + CW'(1);
        mask_reg   <= NUM_CORES'(1) << c_sel;
      end else if (state_reg == COOLDOWN) begin
        mask_reg <= '0;
      end
    end
  end

  assign set_pc   = set_pc_reg;
  assign new_pc   = new_pc_reg;
  assign overflow = overflow_reg;
  assign busy     = (state_reg != IDLE) || (|pending);

endmodule
